alu: RTL and testbench
======================

Name: alu

Overview:
- Registered, single-cycle integer ALU.
- Computes arithmetic, logic and shift results on two WIDTH-bit operands and registers the result with zero/carry/overflow/negative status flags.
- Used as the execute-stage datapath element: an upstream controller drives opcode/operands with enable, and downstream logic samples result/flags one clock later.

Parameters:
- WIDTH, 32, operand/result width in bits; legal values are powers of two, 8 to 64.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
- enable  input  1  when 1, the operation is captured on this clock edge.
- opcode  input  4  operation select (encoding below).
- operand_a  input  WIDTH  first operand / shift source.
- operand_b  input  WIDTH  second operand.
- shift_amount  input  $clog2(WIDTH) (5 for WIDTH=32)  shift distance for shift opcodes.
- result  output  WIDTH  registered result.
- zero_flag  output  1  registered; 1 when the registered result == 0.
- carry_flag  output  1  registered carry/borrow/shift-out bit.
- overflow_flag  output  1  registered signed overflow.
- negative_flag  output  1  registered result[WIDTH-1].
- ready  output  1  registered; 1 = unit out of reset and outputs valid.

Behaviour:
- Reset (reset==0 at a clk edge): result=0, zero_flag=0, carry_flag=0, overflow_flag=0, negative_flag=0, ready=0. Reset overrides enable.
- Reset mid-operation discards the in-flight result.
- ready: 0 during reset; 1 from the first clk edge with reset==1; stays 1 until the next reset. ready does not depend on enable.
- Latency: enable=1 at edge N -> result/flags reflect inputs sampled at edge N and are visible after edge N. Throughput is one operation per cycle.
- enable==0: result and all flags hold their previous values.
- Opcodes (a=operand_a, b=operand_b, s=shift_amount):
  - 0 ADD: a+b; carry = bit WIDTH of the (WIDTH+1)-bit sum; overflow = a,b same sign and result sign differs.
  - 1 SUB: a-b; carry = borrow (1 when a<b unsigned); overflow = a,b signs differ and result sign != a sign.
  - 2 AND: a&b. 3 OR: a|b. 4 XOR: a^b.
  - 5 NOT: ~a (b ignored).
  - 6 SLL: a<<s; carry = last bit shifted out (a[WIDTH-s]), 0 when s==0.
  - 7 SRL: a>>s logical; carry = a[s-1], 0 when s==0.
  - 8 SRA: arithmetic a>>>s; carry as SRL.
  - 9 SLT: (signed a < signed b) ? 1 : 0.
  - A SLTU: (unsigned a < unsigned b) ? 1 : 0.
  - B PASSB: b.
  - C-F reserved: result=0.
- Carry and overflow are 0 for every opcode except where defined above; overflow is defined for ADD/SUB only.
- zero_flag and negative_flag are derived from the new result for every opcode, including reserved ones (reserved -> zero_flag=1).
- All arithmetic wraps modulo 2^WIDTH. Shift amounts use the full shift_amount range (0..WIDTH-1); no modulo beyond that width.

Test Plan:
- Reset held low 2 cycles, then released -> result=0, all flags 0 during reset; ready=1 one edge after release.
- ADD a=0xA, b=0x5 -> result=0x0000000F, zero=0, carry=0. ADD 0xFFFFFFFF+1 -> result=0, zero=1, carry=1. ADD 0x7FFFFFFF+1 -> overflow=1, negative=1.
- SUB a=0xF, b=0x5 -> 0x0000000A. SUB a=5, b=0xF -> 0xFFFFFFF6, negative=1, carry(borrow)=1.
- AND/OR/XOR with a=0xF, b=0xA -> 0xA / 0xF / 0x5; NOT a=0xF -> 0xFFFFFFF0, negative=1.
- SLL a=0xF, s=2 -> 0x3C; SRL a=0x3C, s=2 -> 0xF; SRA a=0x80000000, s=4 -> 0xF8000000.
- Hold with enable=0 after an ADD producing 0xF, then change operands -> result stays 0xF. Assert reset while enable=1 -> result=0, ready=0 at that edge.

Source files
------------

// File: rtl/alu.sv
// Registered single-cycle integer ALU for the execute stage.
// Result and status flags appear one clock after enable is sampled.
module alu #(
    parameter int WIDTH = 32,
    parameter int SW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [SW-1:0]    shift_amount,
    output logic [WIDTH-1:0] result,
    output logic             zero_flag,
    output logic             carry_flag,
    output logic             overflow_flag,
    output logic             negative_flag,
    output logic             ready
);

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_AND   = 4'h2;
    localparam logic [3:0] OP_OR    = 4'h3;
    localparam logic [3:0] OP_XOR   = 4'h4;
    localparam logic [3:0] OP_NOT   = 4'h5;
    localparam logic [3:0] OP_SLL   = 4'h6;
    localparam logic [3:0] OP_SRL   = 4'h7;
    localparam logic [3:0] OP_SRA   = 4'h8;
    localparam logic [3:0] OP_SLT   = 4'h9;
    localparam logic [3:0] OP_SLTU  = 4'hA;
    localparam logic [3:0] OP_PASSB = 4'hB;

    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             neg_q, neg_d;
    logic             ready_q;

    logic [WIDTH:0]        sum_ext;
    logic [WIDTH:0]        diff_ext;
    logic [WIDTH:0]        sll_ext;
    logic [WIDTH:0]        srl_ext;
    logic signed [WIDTH:0] sra_ext;
    logic                  sa, sb;

    // Extended arithmetic/shift results: the extra bit carries out the
    // carry/borrow or the last bit shifted out (zero when shifting by 0).
    assign sum_ext  = {1'b0, operand_a} + {1'b0, operand_b};
    assign diff_ext = {1'b0, operand_a} - {1'b0, operand_b};
    assign sll_ext  = {1'b0, operand_a} << shift_amount;
    assign srl_ext  = {operand_a, 1'b0} >> shift_amount;
    assign sra_ext  = $signed({operand_a, 1'b0}) >>> shift_amount;
    assign sa       = operand_a[WIDTH-1];
    assign sb       = operand_b[WIDTH-1];

    // Next result and carry/overflow selected by opcode; reserved -> 0.
    always_comb begin
        result_d = '0;
        carry_d  = 1'b0;
        ovf_d    = 1'b0;
        case (opcode)
            OP_ADD: begin
                result_d = sum_ext[WIDTH-1:0];
                carry_d  = sum_ext[WIDTH];
                ovf_d    = (sa == sb) && (sum_ext[WIDTH-1] != sa);
            end
            OP_SUB: begin
                result_d = diff_ext[WIDTH-1:0];
                carry_d  = diff_ext[WIDTH];
                ovf_d    = (sa != sb) && (diff_ext[WIDTH-1] != sa);
            end
            OP_AND:   result_d = operand_a & operand_b;
            OP_OR:    result_d = operand_a | operand_b;
            OP_XOR:   result_d = operand_a ^ operand_b;
            OP_NOT:   result_d = ~operand_a;
            OP_SLL: begin
                result_d = sll_ext[WIDTH-1:0];
                carry_d  = sll_ext[WIDTH];
            end
            OP_SRL: begin
                result_d = srl_ext[WIDTH:1];
                carry_d  = srl_ext[0];
            end
            OP_SRA: begin
                result_d = sra_ext[WIDTH:1];
                carry_d  = sra_ext[0];
            end
            OP_SLT: begin
                result_d = {{(WIDTH-1){1'b0}},
                            ($signed(operand_a) < $signed(operand_b))};
            end
            OP_SLTU: begin
                result_d = {{(WIDTH-1){1'b0}}, (operand_a < operand_b)};
            end
            OP_PASSB: result_d = operand_b;
            default:  result_d = '0;
        endcase
        zero_d = (result_d == '0);
        neg_d  = result_d[WIDTH-1];
    end

    // Output registers: reset clears, enable captures, otherwise hold.
    always_ff @(posedge clk) begin
        if (!reset) begin
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            neg_q    <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            if (enable) begin
                result_q <= result_d;
                zero_q   <= zero_d;
                carry_q  <= carry_d;
                ovf_q    <= ovf_d;
                neg_q    <= neg_d;
            end
        end
    end

    assign result        = result_q;
    assign zero_flag     = zero_q;
    assign carry_flag    = carry_q;
    assign overflow_flag = ovf_q;
    assign negative_flag = neg_q;
    assign ready         = ready_q;

endmodule

// File: tb/tb_alu.sv
// Testbench for alu: directed vector table, hand sequences for hold and
// reset, and randomized operations against an arithmetic reference model.
module tb_alu;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [3:0]  opcode;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [4:0]  shift_amount;
    logic [31:0] result;
    logic        zero_flag, carry_flag, overflow_flag, negative_flag;
    logic        ready;

    int n_cmp = 0;
    int n_bad = 0;

    alu #(.WIDTH(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .opcode        (opcode),
        .operand_a     (operand_a),
        .operand_b     (operand_b),
        .shift_amount  (shift_amount),
        .result        (result),
        .zero_flag     (zero_flag),
        .carry_flag    (carry_flag),
        .overflow_flag (overflow_flag),
        .negative_flag (negative_flag),
        .ready         (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  s;
        logic [31:0] r;
        logic        z, c, v, n;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] r,
                           input logic z, input logic c,
                           input logic v, input logic n);
        chk({tag, ".result"}, result, r);
        chk({tag, ".flags"},
            {28'd0, zero_flag, carry_flag, overflow_flag, negative_flag},
            {28'd0, z, c, v, n});
    endtask

    task automatic drive(input logic en, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] s);
        enable       = en;
        opcode       = op;
        operand_a    = a;
        operand_b    = b;
        shift_amount = s;
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic on 64-bit values.
    task automatic model(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] s,
                         output logic [31:0] r, output logic z,
                         output logic c, output logic v,
                         output logic n);
        longint ua, ub, t, sa, sb, st;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = 32'd0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            4'h0: begin
                t  = ua + ub;
                r  = t[31:0];
                c  = (t >= 64'sd4294967296);
                st = sa + sb;
                v  = (st > 64'sd2147483647) || (st < -64'sd2147483648);
            end
            4'h1: begin
                t  = ua - ub;
                r  = t[31:0];
                c  = (ua < ub);
                st = sa - sb;
                v  = (st > 64'sd2147483647) || (st < -64'sd2147483648);
            end
            4'h2: r = a & b;
            4'h3: r = a | b;
            4'h4: r = a ^ b;
            4'h5: r = ~a;
            4'h6: begin
                t = ua * (64'sd1 <<< s);
                r = t[31:0];
                c = (s != 0) && t[32];
            end
            4'h7: begin
                t = ua / (64'sd1 <<< s);
                r = t[31:0];
                c = (s != 0) && (((ua >> (s - 1)) % 2) == 1);
            end
            4'h8: begin
                st = sa >>> s;
                r  = st[31:0];
                c  = (s != 0) && (((ua >> (s - 1)) % 2) == 1);
            end
            4'h9: r = (sa < sb) ? 32'd1 : 32'd0;
            4'hA: r = (ua < ub) ? 32'd1 : 32'd0;
            4'hB: r = b;
            default: r = 32'd0;
        endcase
        z = (r == 32'd0);
        n = r[31];
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [4:0] s,
                                input logic [31:0] r, input logic z,
                                input logic c, input logic v,
                                input logic n);
        vec_t x;
        x.op = op; x.a = a; x.b = b; x.s = s;
        x.r = r; x.z = z; x.c = c; x.v = v; x.n = n;
        return x;
    endfunction

    logic [31:0] mr;
    logic        mz, mc, mv, mn;
    logic [31:0] hr;
    logic        hz, hc, hv, hn;
    logic        en;
    logic [3:0]  op;
    logic [31:0] ra, rb;
    logic [4:0]  rs;

    initial begin
        vecs.push_back(mk(4'h0, 32'hA, 32'h5, 0, 32'hF, 0, 0, 0, 0));
        vecs.push_back(mk(4'h0, 32'hFFFFFFFF, 32'h1, 0, 32'h0, 1, 1, 0, 0));
        vecs.push_back(mk(4'h0, 32'h7FFFFFFF, 32'h1, 0, 32'h80000000, 0, 0, 1, 1));
        vecs.push_back(mk(4'h1, 32'hF, 32'h5, 0, 32'hA, 0, 0, 0, 0));
        vecs.push_back(mk(4'h1, 32'h5, 32'hF, 0, 32'hFFFFFFF6, 0, 1, 0, 1));
        vecs.push_back(mk(4'h1, 32'h80000000, 32'h1, 0, 32'h7FFFFFFF, 0, 0, 1, 0));
        vecs.push_back(mk(4'h2, 32'hF, 32'hA, 0, 32'hA, 0, 0, 0, 0));
        vecs.push_back(mk(4'h3, 32'hF, 32'hA, 0, 32'hF, 0, 0, 0, 0));
        vecs.push_back(mk(4'h4, 32'hF, 32'hA, 0, 32'h5, 0, 0, 0, 0));
        vecs.push_back(mk(4'h5, 32'hF, 32'h1234, 0, 32'hFFFFFFF0, 0, 0, 0, 1));
        vecs.push_back(mk(4'h6, 32'hF, 32'h0, 2, 32'h3C, 0, 0, 0, 0));
        vecs.push_back(mk(4'h7, 32'h3C, 32'h0, 2, 32'hF, 0, 0, 0, 0));
        vecs.push_back(mk(4'h8, 32'h80000000, 32'h0, 4, 32'hF8000000, 0, 0, 0, 1));
        vecs.push_back(mk(4'h6, 32'h80000001, 32'h0, 1, 32'h2, 0, 1, 0, 0));
        vecs.push_back(mk(4'h7, 32'h3, 32'h0, 1, 32'h1, 0, 1, 0, 0));
        vecs.push_back(mk(4'h6, 32'hF, 32'h0, 0, 32'hF, 0, 0, 0, 0));
        vecs.push_back(mk(4'h7, 32'h80000000, 32'h0, 31, 32'h1, 0, 0, 0, 0));
        vecs.push_back(mk(4'h9, 32'hFFFFFFFF, 32'h1, 0, 32'h1, 0, 0, 0, 0));
        vecs.push_back(mk(4'hA, 32'hFFFFFFFF, 32'h1, 0, 32'h0, 1, 0, 0, 0));
        vecs.push_back(mk(4'hB, 32'h5, 32'h80000000, 0, 32'h80000000, 0, 0, 0, 1));
        vecs.push_back(mk(4'hC, 32'h5, 32'h5, 3, 32'h0, 1, 0, 0, 0));
        vecs.push_back(mk(4'hF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'h0, 1, 0, 0, 0));

        reset = 1'b0;
        enable = 1'b1;
        opcode = 4'h0;
        operand_a = 32'hA;
        operand_b = 32'h5;
        shift_amount = 5'd0;

        // Reset held two cycles with enable high
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_all("reset", 32'h0, 0, 0, 0, 0);
        chk("reset.ready", {31'd0, ready}, 32'd0);
        reset = 1'b1;
        drive(1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
        chk("release.ready", {31'd0, ready}, 32'd1);
        chk_all("release.hold", 32'h0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].s);
            chk_all($sformatf("vec%0d", i), vecs[i].r, vecs[i].z,
                    vecs[i].c, vecs[i].v, vecs[i].n);
        end

        // Hold: ADD -> 0xF, then enable low with new operands
        drive(1'b1, 4'h0, 32'hA, 32'h5, 5'd0);
        drive(1'b0, 4'h1, 32'h1, 32'h9, 5'd3);
        drive(1'b0, 4'hB, 32'h0, 32'h0, 5'd0);
        chk_all("hold", 32'hF, 0, 0, 0, 0);
        chk("hold.ready", {31'd0, ready}, 32'd1);

        // Reset while enabled discards the operation
        reset = 1'b0;
        drive(1'b1, 4'h0, 32'h7FFFFFFF, 32'h1, 5'd0);
        chk_all("midreset", 32'h0, 0, 0, 0, 0);
        chk("midreset.ready", {31'd0, ready}, 32'd0);
        reset = 1'b1;
        drive(1'b1, 4'h3, 32'hF0, 32'h0F, 5'd0);
        chk("after.ready", {31'd0, ready}, 32'd1);
        chk_all("after", 32'hFF, 0, 0, 0, 0);

        // Randomized run against the model; held values track enable
        hr = 32'hFF; hz = 0; hc = 0; hv = 0; hn = 0;
        for (int k = 0; k < 400; k++) begin
            en = ($urandom_range(0, 3) != 0);
            op = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: ra = 32'h80000000;
                1: rb = 32'hFFFFFFFF;
                2: rb = ra;
                3: ra = 32'h7FFFFFFF;
                default: ;
            endcase
            rs = 5'($urandom_range(0, 31));
            drive(en, op, ra, rb, rs);
            if (en) begin
                model(op, ra, rb, rs, mr, mz, mc, mv, mn);
                hr = mr; hz = mz; hc = mc; hv = mv; hn = mn;
            end
            chk_all($sformatf("rnd%0d.op%0h", k, op), hr, hz, hc, hv, hn);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
